// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request at a time, a single-entry
// holding buffer towards decode, and redirect/trap steering with kill of in-flight data.
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  output logic [31:0] pc_out
);

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic        flush;
  logic [31:0] target_raw;
  logic [31:0] target;

  // Trap wins over redirect; targets are always forced to word alignment.
  assign flush      = trap_valid | redirect_valid;
  assign target_raw = trap_valid ? trap_vector : redirect_pc;
  assign target     = target_raw & ~32'h0000_0003;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    case (state_q)
      S_REQ: begin
        if (flush) begin
          pc_d = target;
          if (imem_gnt) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush) begin
          pc_d = target;
          // A response arriving with the redirect is stale and finishes the kill at once.
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (flush) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (if_ready) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // The request is masked while reset is held so nothing is issued before release.
  assign imem_req  = (state_q == S_REQ) && !reset;
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == S_HOLD);
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign pc_out    = pc_q;

endmodule
